// File: rtl/vproc_pkg.sv
// Shared constants for the vector-processor result path.
package vproc_pkg;

    localparam int unsigned XIF_DATA_W   = 32;
    localparam int unsigned XIF_RD_W     = 5;
    localparam int unsigned XIF_EXCCODE_W = 6;
    localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/vproc_xif.sv
// Coprocessor result channel between the vector unit and the host core.
interface vproc_xif #(
    parameter int unsigned X_ID_WIDTH = 3
) ();

    logic result_valid;
    logic result_ready;

    struct packed {
        logic [X_ID_WIDTH-1:0]                id;
        logic [vproc_pkg::XIF_DATA_W-1:0]    data;
        logic [vproc_pkg::XIF_RD_W-1:0]      rd;
        logic                                we;
        logic                                exc;
        logic [vproc_pkg::XIF_EXCCODE_W-1:0] exccode;
    } result;

    modport coproc_result (output result_valid, output result, input result_ready);
    modport cpu_result    (input result_valid, input result, output result_ready);

endinterface

// File: rtl/vproc_rr_arbiter.sv
// Fixed-priority or round-robin arbiter with one-hot grant and internal pointer.
module vproc_rr_arbiter #(
    parameter int unsigned N       = 3,
    parameter bit          RR_MODE = 1'b0
) (
    input  logic         clk_i,
    input  logic         async_rst_ni,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] gnt_o
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;

    // First pass searches from the pointer upward (RR only), second pass wraps.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (!found && req_i[i] && (!RR_MODE || i >= int'(ptr_q))) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (!found && req_i[i]) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Pointer moves just past the granted index when the grant is consumed.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            for (int i = 0; i < int'(N); i++) begin
                if (gnt_o[i]) begin
                    ptr_d = (i == int'(N) - 1) ? '0 : PTR_W'(i + 1);
                end
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vproc_result_arb.sv
// Merges per-source results and empty-result requests into one registered
// xif result channel, with starvation protection for empty results.
module vproc_result_arb
    import vproc_pkg::*;
#(
    parameter int unsigned XIF_ID_W       = 3,
    parameter int unsigned SRC_CNT        = 3,
    parameter bit          RR_MODE        = 1'b0,
    parameter int unsigned STARVE_MAX     = 4,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                                    clk_i,
    input  logic                                    async_rst_ni,
    input  logic [SRC_CNT-1:0]                      src_valid_i,
    output logic [SRC_CNT-1:0]                      src_ready_o,
    input  logic [SRC_CNT-1:0][XIF_ID_W-1:0]        src_id_i,
    input  logic [SRC_CNT-1:0][XIF_DATA_W-1:0]      src_data_i,
    input  logic [SRC_CNT-1:0][XIF_RD_W-1:0]        src_rd_i,
    input  logic [SRC_CNT-1:0]                      src_we_i,
    input  logic [SRC_CNT-1:0]                      src_exc_i,
    input  logic [SRC_CNT-1:0][XIF_EXCCODE_W-1:0]   src_exccode_i,
    input  logic                                    empty_valid_i,
    input  logic [XIF_ID_W-1:0]                     empty_id_i,
    vproc_xif.coproc_result                         xif_result_if
);

    localparam int unsigned XIF_ID_CNT = 1 << XIF_ID_W;
    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);
    localparam logic DC = DONT_CARE_ZERO ? 1'b0 : 1'bx;

    typedef enum logic [1:0] {GNT_NONE, GNT_SRC, GNT_EMPTY} gnt_sel_e;

    gnt_sel_e                  sel;
    logic                      load_en, advance, starve_hit;
    logic [SRC_CNT-1:0]        src_gnt;
    logic [XIF_ID_CNT-1:0]     pend_q, pend_d, empty_clr, empty_set;
    logic [XIF_ID_W-1:0]       empty_idx;
    logic [STARVE_CNT_W-1:0]   starve_q, starve_d;
    logic                      valid_q, valid_d, we_q, we_d, exc_q, exc_d;
    logic [XIF_ID_W-1:0]       id_q, id_d;
    logic [XIF_DATA_W-1:0]     data_q, data_d;
    logic [XIF_RD_W-1:0]       rd_q, rd_d;
    logic [XIF_EXCCODE_W-1:0]  exccode_q, exccode_d;

    assign load_en    = ~valid_q | xif_result_if.result_ready;
    assign starve_hit = (starve_q >= STARVE_LIM) && (|pend_q);
    assign advance    = load_en && (sel == GNT_SRC);
    assign src_ready_o = src_gnt & {SRC_CNT{advance & async_rst_ni}};

    vproc_rr_arbiter #(
        .N       (SRC_CNT),
        .RR_MODE (RR_MODE)
    ) u_src_arb (
        .clk_i        (clk_i),
        .async_rst_ni (async_rst_ni),
        .req_i        (src_valid_i),
        .advance_i    (advance),
        .gnt_o        (src_gnt)
    );

    // Lowest pending empty ID (descending scan so the lowest bit wins).
    always_comb begin
        empty_idx = '0;
        for (int i = int'(XIF_ID_CNT) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                empty_idx = XIF_ID_W'(i);
            end
        end
    end

    // Grant selection, output-register next state, bitmap and starve counter.
    always_comb begin
        sel       = GNT_NONE;
        valid_d   = valid_q;
        we_d      = we_q;
        exc_d     = exc_q;
        id_d      = id_q;
        data_d    = data_q;
        rd_d      = rd_q;
        exccode_d = exccode_q;
        empty_clr = '0;
        empty_set = '0;
        starve_d  = starve_q;

        if (starve_hit)         sel = GNT_EMPTY;
        else if (|src_valid_i)  sel = GNT_SRC;
        else if (|pend_q)       sel = GNT_EMPTY;

        if (load_en) begin
            valid_d   = (sel != GNT_NONE);
            we_d      = 1'b0;
            exc_d     = 1'b0;
            id_d      = {XIF_ID_W{DC}};
            data_d    = {XIF_DATA_W{DC}};
            rd_d      = {XIF_RD_W{DC}};
            exccode_d = {XIF_EXCCODE_W{DC}};
            if (sel == GNT_SRC) begin
                for (int i = 0; i < int'(SRC_CNT); i++) begin
                    if (src_gnt[i]) begin
                        id_d      = src_id_i[i];
                        data_d    = src_data_i[i];
                        rd_d      = src_rd_i[i];
                        we_d      = src_we_i[i];
                        exc_d     = src_exc_i[i];
                        exccode_d = src_exccode_i[i];
                    end
                end
            end else if (sel == GNT_EMPTY) begin
                id_d      = empty_idx;
                empty_clr = XIF_ID_CNT'(1) << empty_idx;
            end
        end

        // A new request for an ID being granted this cycle must survive.
        if (empty_valid_i) begin
            empty_set = XIF_ID_CNT'(1) << empty_id_i;
        end
        pend_d = (pend_q & ~empty_clr) | empty_set;

        if (pend_q == '0 || (load_en && sel == GNT_EMPTY)) begin
            starve_d = '0;
        end else if (advance && starve_q < STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            exc_q    <= 1'b0;
            pend_q   <= '0;
            starve_q <= '0;
        end else begin
            valid_q  <= valid_d;
            we_q     <= we_d;
            exc_q    <= exc_d;
            pend_q   <= pend_d;
            starve_q <= starve_d;
        end
    end

    // Payload registers carry no reset; they are qualified by valid_q.
    always_ff @(posedge clk_i) begin
        id_q      <= id_d;
        data_q    <= data_d;
        rd_q      <= rd_d;
        exccode_q <= exccode_d;
    end

    assign xif_result_if.result_valid   = valid_q;
    assign xif_result_if.result.id      = id_q;
    assign xif_result_if.result.data    = data_q;
    assign xif_result_if.result.rd      = rd_q;
    assign xif_result_if.result.we      = valid_q & we_q;
    assign xif_result_if.result.exc     = valid_q & exc_q;
    assign xif_result_if.result.exccode = exccode_q;

endmodule

// File: tb/tb_vproc_result_arb.sv
// Directed bench: one fixed-priority and one round-robin instance share stimulus.
module tb_vproc_result_arb;

    logic             clk;
    logic             rst_n;
    logic [2:0]       src_valid;
    logic [2:0]       src_ready_fp, src_ready_rr;
    logic [2:0][2:0]  src_id;
    logic [2:0][31:0] src_data;
    logic [2:0][4:0]  src_rd;
    logic [2:0]       src_we, src_exc;
    logic [2:0][5:0]  src_exccode;
    logic             empty_valid;
    logic [2:0]       empty_id;

    int tests_run    = 0;
    int tests_failed = 0;

    vproc_xif #(.X_ID_WIDTH(3)) xif_fp ();
    vproc_xif #(.X_ID_WIDTH(3)) xif_rr ();

    vproc_result_arb #(.XIF_ID_W(3), .SRC_CNT(3), .RR_MODE(1'b0), .STARVE_MAX(4), .DONT_CARE_ZERO(1'b1)) dut_fp (
        .clk_i(clk), .async_rst_ni(rst_n), .src_valid_i(src_valid), .src_ready_o(src_ready_fp),
        .src_id_i(src_id), .src_data_i(src_data), .src_rd_i(src_rd), .src_we_i(src_we),
        .src_exc_i(src_exc), .src_exccode_i(src_exccode), .empty_valid_i(empty_valid),
        .empty_id_i(empty_id), .xif_result_if(xif_fp)
    );

    vproc_result_arb #(.XIF_ID_W(3), .SRC_CNT(3), .RR_MODE(1'b1), .STARVE_MAX(4), .DONT_CARE_ZERO(1'b1)) dut_rr (
        .clk_i(clk), .async_rst_ni(rst_n), .src_valid_i(src_valid), .src_ready_o(src_ready_rr),
        .src_id_i(src_id), .src_data_i(src_data), .src_rd_i(src_rd), .src_we_i(src_we),
        .src_exc_i(src_exc), .src_exccode_i(src_exccode), .empty_valid_i(empty_valid),
        .empty_id_i(empty_id), .xif_result_if(xif_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic r);
        xif_fp.result_ready = r;
        xif_rr.result_ready = r;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_ready(1'b1);
        repeat (2) @(posedge clk);
        #1;
        src_valid = 3'b111;
        #1;
        tests_run++;
        if (src_ready_fp !== 3'b000) begin tests_failed++; $display("FAIL reset_ready_fp: got %b expected 000", src_ready_fp); end
        tests_run++;
        if (src_ready_rr !== 3'b000) begin tests_failed++; $display("FAIL reset_ready_rr: got %b expected 000", src_ready_rr); end
        tests_run++;
        if (xif_fp.result_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid_fp: got %b expected 0", xif_fp.result_valid); end
        src_valid = 3'b000;
        tick();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (xif_rr.result_valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_valid_rr: got %b expected 0", xif_rr.result_valid); end
        $display("[TB] reset: valid=%b", xif_fp.result_valid);
    endtask

    task automatic test_single();
        src_id[1] = 3'd5; src_data[1] = 32'hDEAD_BEEF; src_rd[1] = 5'd7;
        src_we[1] = 1'b1; src_exc[1] = 1'b0; src_exccode[1] = 6'd0;
        src_valid = 3'b010;
        #1;
        tests_run++;
        if (src_ready_fp !== 3'b010) begin tests_failed++; $display("FAIL single_ready: got %b expected 010", src_ready_fp); end
        tick();
        src_valid = 3'b000;
        tests_run++;
        if (xif_fp.result_valid !== 1'b1 || xif_fp.result.id !== 3'd5 || xif_fp.result.data !== 32'hDEAD_BEEF
            || xif_fp.result.rd !== 5'd7 || xif_fp.result.we !== 1'b1 || xif_fp.result.exc !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_result: got v=%b id=%0d data=%h rd=%0d we=%b expected v=1 id=5 data=deadbeef rd=7 we=1",
                     xif_fp.result_valid, xif_fp.result.id, xif_fp.result.data, xif_fp.result.rd, xif_fp.result.we);
        end
        tests_run++;
        if (xif_rr.result.data !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL single_rr_data: got %h expected deadbeef", xif_rr.result.data); end
        #1;
        tests_run++;
        if (src_ready_fp !== 3'b000) begin tests_failed++; $display("FAIL single_one_pulse: got %b expected 000", src_ready_fp); end
        $display("[TB] single: id=%0d data=%h", xif_fp.result.id, xif_fp.result.data);
        tick();
        tests_run++;
        if (xif_fp.result_valid !== 1'b0 || xif_fp.result.we !== 1'b0) begin
            tests_failed++; $display("FAIL single_drain: got v=%b we=%b expected v=0 we=0", xif_fp.result_valid, xif_fp.result.we);
        end
    endtask

    task automatic test_backpressure();
        set_ready(1'b0);
        src_id[0] = 3'd1; src_data[0] = 32'h1111_0000; src_rd[0] = 5'd3;
        src_we[0] = 1'b1; src_exc[0] = 1'b1; src_exccode[0] = 6'h2A;
        src_valid = 3'b001;
        #1;
        tests_run++;
        if (src_ready_fp !== 3'b001) begin tests_failed++; $display("FAIL bp_first_ready: got %b expected 001", src_ready_fp); end
        tick();
        src_id[0] = 3'd2; src_data[0] = 32'h2222_0000; src_rd[0] = 5'd4;
        src_we[0] = 1'b0; src_exc[0] = 1'b0; src_exccode[0] = 6'h15;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if (src_ready_fp !== 3'b000) begin tests_failed++; $display("FAIL bp_stall_ready[%0d]: got %b expected 000", k, src_ready_fp); end
            tests_run++;
            if (xif_fp.result_valid !== 1'b1 || xif_fp.result.id !== 3'd1 || xif_fp.result.data !== 32'h1111_0000
                || xif_fp.result.rd !== 5'd3 || xif_fp.result.we !== 1'b1 || xif_fp.result.exc !== 1'b1
                || xif_fp.result.exccode !== 6'h2A) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d data=%h rd=%0d we=%b exc=%b code=%h expected v=1 id=1 data=11110000 rd=3 we=1 exc=1 code=2a",
                         k, xif_fp.result_valid, xif_fp.result.id, xif_fp.result.data, xif_fp.result.rd,
                         xif_fp.result.we, xif_fp.result.exc, xif_fp.result.exccode);
            end
            tick();
        end
        set_ready(1'b1);
        #1;
        tests_run++;
        if (src_ready_fp !== 3'b001) begin tests_failed++; $display("FAIL bp_release_ready: got %b expected 001", src_ready_fp); end
        tick();
        src_valid = 3'b000;
        tests_run++;
        if (xif_fp.result.id !== 3'd2 || xif_fp.result.data !== 32'h2222_0000 || xif_fp.result.we !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_second: got id=%0d data=%h we=%b expected id=2 data=22220000 we=0",
                     xif_fp.result.id, xif_fp.result.data, xif_fp.result.we);
        end
        tests_run++;
        if (xif_rr.result.id !== 3'd2) begin tests_failed++; $display("FAIL bp_second_rr: got %0d expected 2", xif_rr.result.id); end
        $display("[TB] backpressure: id=%0d data=%h", xif_fp.result.id, xif_fp.result.data);
        tick();
    endtask

    task automatic test_empty_order();
        logic [2:0] exp_ids [3] = '{3'd2, 3'd4, 3'd6};
        set_ready(1'b0);
        src_id[2] = 3'd7; src_data[2] = 32'h0000_0077; src_rd[2] = 5'd1;
        src_we[2] = 1'b1; src_exc[2] = 1'b0; src_exccode[2] = 6'd0;
        src_valid = 3'b100;
        tick();
        src_valid = 3'b000;
        empty_valid = 1'b1; empty_id = 3'd6; tick();
        empty_id = 3'd2; tick();
        empty_id = 3'd4; tick();
        empty_valid = 1'b0;
        tests_run++;
        if (xif_fp.result_valid !== 1'b1 || xif_fp.result.id !== 3'd7) begin
            tests_failed++; $display("FAIL empty_held_src: got v=%b id=%0d expected v=1 id=7", xif_fp.result_valid, xif_fp.result.id);
        end
        set_ready(1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if (xif_fp.result_valid !== 1'b1 || xif_fp.result.id !== exp_ids[k] || xif_fp.result.we !== 1'b0 || xif_fp.result.exc !== 1'b0) begin
                tests_failed++;
                $display("FAIL empty_order_fp[%0d]: got v=%b id=%0d we=%b exc=%b expected v=1 id=%0d we=0 exc=0",
                         k, xif_fp.result_valid, xif_fp.result.id, xif_fp.result.we, xif_fp.result.exc, exp_ids[k]);
            end
            tests_run++;
            if (xif_rr.result.id !== exp_ids[k]) begin tests_failed++; $display("FAIL empty_order_rr[%0d]: got %0d expected %0d", k, xif_rr.result.id, exp_ids[k]); end
            $display("[TB] empty result: id=%0d we=%b", xif_fp.result.id, xif_fp.result.we);
        end
        tick();
        tests_run++;
        if (xif_fp.result_valid !== 1'b0) begin tests_failed++; $display("FAIL empty_drained: got %b expected 0", xif_fp.result_valid); end
    endtask

    task automatic test_starve();
        // First load happens before the pending bit is visible, then four
        // source grants with the bit set saturate the counter.
        logic [2:0] exp_ids [7] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd1};
        logic       exp_we  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        set_ready(1'b1);
        src_id[0] = 3'd1; src_data[0] = 32'h0000_00A0; src_rd[0] = 5'd2;
        src_we[0] = 1'b1; src_exc[0] = 1'b0; src_exccode[0] = 6'd0;
        src_valid = 3'b001;
        empty_valid = 1'b1; empty_id = 3'd3;
        tick();
        empty_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tests_run++;
            if (xif_fp.result_valid !== 1'b1 || xif_fp.result.id !== exp_ids[k] || xif_fp.result.we !== exp_we[k]) begin
                tests_failed++;
                $display("FAIL starve_fp[%0d]: got v=%b id=%0d we=%b expected v=1 id=%0d we=%b",
                         k, xif_fp.result_valid, xif_fp.result.id, xif_fp.result.we, exp_ids[k], exp_we[k]);
            end
            tests_run++;
            if (xif_rr.result.id !== exp_ids[k]) begin tests_failed++; $display("FAIL starve_rr[%0d]: got %0d expected %0d", k, xif_rr.result.id, exp_ids[k]); end
            $display("[TB] starve result: id=%0d we=%b", xif_fp.result.id, xif_fp.result.we);
            tick();
        end
        src_valid = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid();
        set_ready(1'b0);
        src_id[1] = 3'd4; src_data[1] = 32'h0000_0044; src_we[1] = 1'b1;
        src_valid = 3'b010;
        tick();
        src_valid = 3'b000;
        empty_valid = 1'b1; empty_id = 3'd1; tick();
        empty_id = 3'd3; tick();
        empty_valid = 1'b0;
        tests_run++;
        if (xif_fp.result_valid !== 1'b1 || xif_fp.result.id !== 3'd4) begin
            tests_failed++; $display("FAIL mid_held: got v=%b id=%0d expected v=1 id=4", xif_fp.result_valid, xif_fp.result.id);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (xif_fp.result_valid !== 1'b0 || xif_rr.result_valid !== 1'b0) begin
            tests_failed++; $display("FAIL mid_async_clear: got fp=%b rr=%b expected 0 0", xif_fp.result_valid, xif_rr.result_valid);
        end
        tick();
        rst_n = 1'b1;
        set_ready(1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if (xif_fp.result_valid !== 1'b0 || xif_rr.result_valid !== 1'b0) begin
                tests_failed++; $display("FAIL mid_no_empty[%0d]: got fp=%b rr=%b expected 0 0", k, xif_fp.result_valid, xif_rr.result_valid);
            end
        end
        $display("[TB] reset mid-transaction: valid=%b", xif_fp.result_valid);
    endtask

    task automatic test_back_to_back();
        set_ready(1'b1);
        for (int s = 0; s < 3; s++) begin
            src_id[s] = 3'(s); src_data[s] = 32'(s); src_rd[s] = 5'(s);
            src_we[s] = 1'b1; src_exc[s] = 1'b0; src_exccode[s] = 6'd0;
        end
        src_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            tests_run++;
            if (src_ready_fp !== 3'b001) begin tests_failed++; $display("FAIL b2b_ready_fp[%0d]: got %b expected 001", k, src_ready_fp); end
            tests_run++;
            if (src_ready_rr !== 3'(1 << (k % 3))) begin tests_failed++; $display("FAIL b2b_ready_rr[%0d]: got %b expected %b", k, src_ready_rr, 3'(1 << (k % 3))); end
            tick();
            tests_run++;
            if (xif_fp.result_valid !== 1'b1 || xif_fp.result.id !== 3'd0) begin
                tests_failed++; $display("FAIL b2b_fp[%0d]: got v=%b id=%0d expected v=1 id=0", k, xif_fp.result_valid, xif_fp.result.id);
            end
            tests_run++;
            if (xif_rr.result_valid !== 1'b1 || xif_rr.result.id !== 3'(k % 3)) begin
                tests_failed++; $display("FAIL b2b_rr[%0d]: got v=%b id=%0d expected v=1 id=%0d", k, xif_rr.result_valid, xif_rr.result.id, k % 3);
            end
            $display("[TB] b2b: fp id=%0d rr id=%0d", xif_fp.result.id, xif_rr.result.id);
        end
        src_valid = 3'b000;
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        src_valid   = '0;
        src_id      = '0;
        src_data    = '0;
        src_rd      = '0;
        src_we      = '0;
        src_exc     = '0;
        src_exccode = '0;
        empty_valid = 1'b0;
        empty_id    = '0;
        set_ready(1'b1);
        test_reset();
        test_single();
        test_backpressure();
        test_empty_order();
        test_starve();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vproc_result_arb.md
VPROC_RESULT_ARB -- requirements
Module: vproc_result_arb

Interface
REQ-001 SHALL have parameter XIF_ID_W, default 3, instruction ID width.
REQ-002 SHALL have parameter SRC_CNT, default 3, range 1..8, number of result sources; index 0 has the highest fixed priority.
REQ-003 SHALL have parameter RR_MODE, default 1'b0; 0 selects fixed priority, 1 selects round-robin among sources.
REQ-004 SHALL have parameter STARVE_MAX, default 4, range 1..15: consecutive source grants after which pending empty results take precedence.
REQ-005 SHALL have parameter DONT_CARE_ZERO, default 1'b0; 1 drives don't-care outputs to zero, otherwise X.
REQ-006 Port clk_i, input, 1, sole clock, rising edge.
REQ-007 Port async_rst_ni, input, 1, reset: asynchronous, active-low.
REQ-008 Port src_valid_i / src_ready_o, input / output, SRC_CNT, per-source valid/ready handshake.
REQ-009 Ports src_id_i, src_data_i, src_rd_i, src_we_i, src_exc_i, src_exccode_i, all inputs, widths SRC_CNT x {XIF_ID_W, 32, 5, 1, 1, 6}, per-source result fields.
REQ-010 Port empty_valid_i / empty_id_i, input, 1 / XIF_ID_W, request for an empty (no-data) result; no ready.
REQ-011 Port xif_result_if, vproc_xif.coproc_result modport, carries result_valid, result_ready and result {id, data, rd, we, exc, exccode}.

Function
REQ-012 SHALL register every result in a one-entry output register: xif result fields come only from register contents, so source-accept-to-result_valid latency is 1 cycle.
REQ-013 Output register SHALL load when empty or when result_valid & result_ready (same-cycle drain and refill, back-to-back throughput 1/cycle).
REQ-014 While result_valid & ~result_ready, all xif result fields SHALL hold stable.
REQ-015 src_ready_o[i] SHALL be high only for the single granted source in a cycle where the register loads; a source transfer is src_valid_i[i] & src_ready_o[i].
REQ-016 Empty requests SHALL set bit empty_id_i in an XIF_ID_CNT-bit pending bitmap (XIF_ID_CNT = 2^XIF_ID_W) at the next edge, regardless of ready.
REQ-017 Empty grants SHALL pick the lowest set pending bit, clear it on load, and load id with we=0, exc=0.
REQ-018 Same-cycle set and clear of the same bit: set SHALL win.
REQ-019 Grant order: if starve count >= STARVE_MAX and bitmap non-zero, empty is granted; else sources (fixed or round-robin); else empty if bitmap non-zero.
REQ-020 Starve counter SHALL increment (saturating at STARVE_MAX) on each source grant while bitmap non-zero, and clear on empty grant or empty bitmap.
REQ-021 Round-robin pointer SHALL advance to granted index+1, wrapping SRC_CNT-1 to 0; it is unchanged when no source is granted.
REQ-022 Unloaded register fields SHALL be don't-care per DONT_CARE_ZERO; we and exc SHALL be 0 when result_valid is 0.

Reset
REQ-023 Reset SHALL clear result_valid, the pending bitmap, the starve counter and the RR pointer (pointer = 0); src_ready_o SHALL be 0 during reset.
REQ-024 Reset mid-transaction SHALL discard the held result and all pending empty IDs, with no xif output the cycle after deassertion.
REQ-025 Data/ID/rd/exccode registers SHALL be non-reset registers.

Structure
REQ-026 Shared package vproc_pkg SHALL hold no new typedefs; the grant source type (sources 0..SRC_CNT-1 plus EMPTY, NONE) is local.
REQ-027 A sub-module vproc_rr_arbiter (parametrised N, fixed/RR mode, request vector in, one-hot grant out, pointer internal) SHALL implement source selection.
REQ-028 Implementation SHALL fit in 120-400 lines of RTL.

Verification
REQ-029 Src1 valid (id=5, data=0xDEAD_BEEF, rd=7, we=1), ready=1 -> next cycle result_valid=1, id=5, data=0xDEADBEEF, rd=7, we=1; one src_ready_o pulse.
REQ-030 Src0 valid, ready=0 for 3 cycles -> fields stable over 3 cycles; src0 not re-accepted; transfer on cycle 4.
REQ-031 Empty ids 6, 2, 4 in consecutive cycles, no sources, ready=1 -> results with id 2, 4, 6 in order, we=0.
REQ-032 STARVE_MAX=4, src0 valid continuously, empty id 3 pending -> 4 src0 results, then id 3, then src0 resumes.
REQ-033 RR_MODE=1, sources 0,1,2 valid continuously -> grant order 0,1,2,0,1,2; RR_MODE=0 -> 0 every cycle.
REQ-034 Reset asserted with result held and bitmap 0b1010 -> after release result_valid=0 and no empty results issued.
